// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: state encoding and default sizing.
package pulse_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_DELAY = DELAY,
        ST_PULSE = PULSE
    } state_e;

endpackage

// File: rtl/pulse_sched_arbiter.sv
// Combinational round-robin pick: first set request strictly above the pointer,
// falling back to the lowest set request when nothing above it is pending.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] upper_req;
    logic [N_REQ-1:0] pick_src;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (IDX_W'(gi) > ptr);
        end
    endgenerate

    assign upper_req = req & upper_mask;
    assign pick_src  = (|upper_req) ? upper_req : req;
    assign win_valid = |req;

    // Scan downward so the lowest set bit of pick_src is the last one written.
    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        win_oh = '0;
        if (win_valid) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Shares one delayed one-shot pulse generator among N_REQ requesters using
// round-robin arbitration; grant, done and dout are all registered.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             dout
);

    localparam int IDX_W = $clog2(N_REQ);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] delay_reg, delay_next;
    logic [CNT_W-1:0] width_reg, width_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [N_REQ-1:0] done_reg, done_next;
    logic             dout_reg, dout_next;

    logic [N_REQ-1:0] arb_oh;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .win_oh    (arb_oh),
        .win_idx   (arb_idx),
        .win_valid (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            delay_reg <= '0;
            width_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= IDX_W'(N_REQ - 1);
            gnt_reg   <= '0;
            done_reg  <= '0;
            dout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            delay_reg <= delay_next;
            width_reg <= width_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            dout_reg  <= dout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        delay_next = delay_reg;
        width_next = width_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        gnt_next   = '0;
        done_next  = '0;
        dout_next  = dout_reg;

        case (state_reg)
            ST_IDLE: begin
                dout_next = 1'b0;
                if (arb_valid) begin
                    gnt_next   = arb_oh;
                    delay_next = delay;
                    width_next = (width == '0) ? CNT_W'(1) : width;
                    owner_next = arb_idx;
                    ptr_next   = arb_idx;
                    cnt_next   = '0;
                    // A zero delay starts the pulse in the same cycle as the grant.
                    if (delay == '0) begin
                        state_next = ST_PULSE;
                        dout_next  = 1'b1;
                    end else begin
                        state_next = ST_DELAY;
                    end
                end
            end

            ST_DELAY: begin
                if (cnt_reg == delay_reg - CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_PULSE;
                    dout_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_PULSE: begin
                if (cnt_reg == width_reg - CNT_W'(1)) begin
                    cnt_next             = '0;
                    state_next           = ST_IDLE;
                    dout_next            = 1'b0;
                    done_next[owner_reg] = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                dout_next  = 1'b0;
            end
        endcase
    end

    assign gnt  = gnt_reg;
    assign done = done_reg;
    assign dout = dout_reg;
    assign busy = (state_reg != ST_IDLE);

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Round-robin scheduler that shares one delayed one-shot pulse generator among N requesters. A requester raises `req`, receives a one-cycle grant, and the block produces `dout` high for a programmable width after a programmable delay. It then returns a one-cycle `done` to the owner. It sits between several control FSMs and the single trigger/strobe line they share, so that no two pulses overlap.

## Interface
- Parameters:
- `N_REQ`, default 4: number of requesters, minimum 2.
- `CNT_W`, default 4: width of the delay and width fields.
- Ports:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, N_REQ: level request per requester; held until granted.
- `delay`, input, CNT_W: cycles from grant to `dout` rise; sampled at grant.
- `width`, input, CNT_W: `dout` high cycles; sampled at grant; 0 is treated as 1.
- `gnt`, output, N_REQ: one-hot, high for exactly one cycle per service.
- `done`, output, N_REQ: one-hot, high for one cycle when the owner's pulse completes.
- `busy`, output, 1: high whenever state is not IDLE.
- `dout`, output, 1: the shared pulse.

## Operation
- **Reset values:** `gnt`=0, `done`=0, `busy`=0, `dout`=0; state=IDLE; internal counter=0. The last-grant pointer resets to N_REQ-1, so requester 0 has first priority.
- **State IDLE:**
  - If `req` is nonzero, pick the first set bit searching upward from pointer+1 with wrap.
  - Register the one-hot grant and latch `delay`, `width` (0 becomes 1) and the owner index. Update the pointer to the winner.
  - Go to DELAY, or to PULSE if `delay`==0.
- **State DELAY:** counter increments each cycle. At counter==delay-1, clear the counter and go to PULSE.
- **State PULSE:** `dout`=1, counter increments. At counter==width-1, clear the counter, go to IDLE, pulse `done[owner]` and drop `dout`.
- **Registered outputs:** `gnt`, `done` and `dout` are registered. `busy` is decoded from state.
- **Changes during service:**
  - `req` changes while not IDLE are ignored.
  - A request withdrawn before grant is never served.
  - `delay` and `width` changes after grant have no effect.
- **Re-request by the owner:** the owner may keep `req` high to request again. It is then served after every other pending requester, per round-robin order.
- **Counters:** CNT_W bits wide and never wrap, because both end conditions are bounded by latched values ≤ 2^CNT_W-1.
- **Reset mid-operation:**
  - All outputs go to 0 immediately (asynchronously) and the state returns to IDLE.
  - A truncated pulse produces no `done`.

## Timing
- `req` sampled at edge T in IDLE → `gnt` high during cycle T+1.
- With delay D and effective width W:
  - `dout` is high in cycles T+1+D through T+D+W.
  - `done` is high in cycle T+1+D+W.
  - `busy` is high in cycles T+1 through T+D+W.
- **IDLE in the done cycle:** the cycle in which `done` is high is spent in IDLE. Arbitration happens there, so the next `gnt` arrives at the earliest in cycle T+2+D+W.
- **Back-to-back service:** `dout` is guaranteed at least one low cycle between services.
- **Exclusivity:** `gnt` and `done` are never high together for the same requester. At most one bit of each is set.

## Structure
- Shared package `pulse_sched_pkg`:
  - State encoding localparams IDLE/DELAY/PULSE (2 bits).
  - Default `N_REQ` and `CNT_W`.
- Sub-module `rr_arbiter`:
  - Combinational round-robin pick.
  - Inputs: `req` and the pointer. Outputs: one-hot winner and its index.
  - Reused later by other shared-resource controllers.
- Top level holds the FSM, counter, latched config and output registers.

## Test plan
- **Reset and single request:** reset, then `req`=0001, `delay`=2, `width`=3 at edge T → `gnt`=0001 at T+1, `dout` high T+3..T+5, `done`=0001 at T+6, `busy` high T+1..T+5.
- **Zero fields:** `delay`=0, `width`=0 → `dout` high for exactly one cycle, coinciding with the `gnt` cycle; `done` the next cycle.
- **Round-robin:** `req`=1111 held constantly → grant order 0,1,2,3,0. Each `dout` pulse is separated by at least one low cycle.
- **Config change mid-service:** change `delay`/`width` and toggle another `req` during DELAY → current pulse timing unchanged, no extra `gnt`.
- **Withdrawn request:** `req[2]` pulsed high while busy and dropped before IDLE → requester 2 is never granted.
- **Reset mid-operation:** assert `rst` mid-PULSE → `dout`, `busy`, `gnt` and `done` go to 0 immediately, no `done` ever issues for that pulse, and requester 0 wins first after release.
